piso_ctrl: RTL and testbench

PISO_CTRL -- requirements
Module: piso_ctrl

---
 rtl/piso_pkg.sv | 26 ++
 rtl/piso_msb.sv | 41 ++++
 rtl/piso_ctrl.sv | 128 ++++++++++++
 tb/tb_piso_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// ---------------------------------------------------------------------------
// piso_pkg
//   Shared definitions for the parallel-in / serial-out controller slice.
//   FRAME_W  : bits per serial frame (one parallel word)
//   CNT_W    : width of the in-frame bit counter
//   state_t  : controller FSM state encoding
//   is_last  : true when the bit counter addresses the final (LSB) bit
// ---------------------------------------------------------------------------
package piso_pkg;

    localparam int FRAME_W = 4;
    localparam int CNT_W   = 2;

    // Counter value on the last bit of a frame (bit 0 of the word).
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,   // shifter empty, nothing on the serial line
        ST_SHIFT = 1'b1    // frame in progress
    } state_t;

    function automatic logic is_last(input logic [CNT_W-1:0] cnt);
        return (cnt == CNT_LAST);
    endfunction

endpackage

// File: rtl/piso_msb.sv
// ---------------------------------------------------------------------------
// piso_msb
//   MSB-first parallel-load shift register.
//   Ports:
//     clk  in   system clock, rising edge
//     rst  in   asynchronous active-low reset, clears the register
//     enb  in   1 = load or shift this edge, 0 = hold
//     l_s  in   1 = load inp, 0 = shift left (zero fill)
//     inp  in   parallel word, DATA_W bits
//     out  out  current MSB of the register
// ---------------------------------------------------------------------------
module piso_msb
    import piso_pkg::*;
#(
    parameter int DATA_W = FRAME_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enb,
    input  logic              l_s,
    input  logic [DATA_W-1:0] inp,
    output logic              out
);

    logic [DATA_W-1:0] sr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_q <= '0;
        end else if (enb) begin
            if (l_s) begin
                sr_q <= inp;
            end else begin
                sr_q <= {sr_q[DATA_W-2:0], 1'b0};
            end
        end
    end

    assign out = sr_q[DATA_W-1];

endmodule

// File: rtl/piso_ctrl.sv
// ---------------------------------------------------------------------------
// piso_ctrl
//   Valid/ready front end for an MSB-first serialiser. A one-word holding
//   register decouples the requester from the shifter so that, with a steady
//   supply of words, frames leave back-to-back with no idle bit between them.
//   Ports:
//     clk         in   system clock, rising edge
//     rst         in   asynchronous active-low reset
//     enb         in   global enable; 0 freezes every register
//     in_valid    in   requester offers in_data
//     in_data     in   parallel word, bit FRAME_W-1 sent first
//     in_ready    out  word is taken at the next edge if in_valid is high
//     ser_out     out  serial bit (shifter MSB)
//     ser_valid   out  ser_out carries a frame bit this cycle
//     ser_first   out  first bit of a frame
//     frame_done  out  last bit of a frame
//     busy        out  frame shifting or word held
// ---------------------------------------------------------------------------
module piso_ctrl
    import piso_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               enb,
    input  logic               in_valid,
    input  logic [FRAME_W-1:0] in_data,
    output logic               in_ready,
    output logic               ser_out,
    output logic               ser_valid,
    output logic               ser_first,
    output logic               frame_done,
    output logic               busy
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [FRAME_W-1:0] hold_q;
    logic               hold_vld_q;
    logic               load_fire;
    logic               accept;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        load_fire  = 1'b0;

        // The shifter can take the held word when it is empty, or on the
        // last bit of the current frame so the next frame follows directly.
        if (enb && hold_vld_q) begin
            load_fire = (state_q == ST_IDLE) ||
                        ((state_q == ST_SHIFT) && is_last(cnt_q));
        end

        // A word leaving the holding register frees it in the same cycle,
        // so accepting and loading may coincide. Gated by rst so the port
        // reads 0 while reset is held.
        in_ready = rst & enb & (~hold_vld_q | load_fire);
        accept   = in_valid & in_ready;

        if (enb) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (load_fire) begin
                        state_d = ST_SHIFT;
                        cnt_d   = '0;
                    end
                end
                ST_SHIFT: begin
                    if (!is_last(cnt_q)) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else if (load_fire) begin
                        cnt_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        ser_valid  = enb & (state_q == ST_SHIFT);
        ser_first  = ser_valid & (cnt_q == '0);
        frame_done = ser_valid & is_last(cnt_q);
        busy       = (state_q == ST_SHIFT) | hold_vld_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // On a simultaneous accept and load the shifter captures the old hold_q
    // at this edge while hold_q takes the new word, so nothing is lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
        end else if (accept) begin
            hold_q     <= in_data;
            hold_vld_q <= 1'b1;
        end else if (load_fire) begin
            hold_vld_q <= 1'b0;
        end
    end

    // Outside a frame the shifter keeps shifting zeros; ser_out is only
    // meaningful while ser_valid is high.
    piso_msb #(
        .DATA_W (FRAME_W)
    ) u_shift (
        .clk (clk),
        .rst (rst),
        .enb (enb),
        .l_s (load_fire),
        .inp (hold_q),
        .out (ser_out)
    );

endmodule

// File: tb/tb_piso_ctrl.sv
module tb_piso_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       enb;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic       ser_out;
    logic       ser_valid;
    logic       ser_first;
    logic       frame_done;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic [3:0] tx_q[$];
    logic       exp_q[$];
    logic       obs_q[$];
    int         n_done = 0;
    int         n_first = 0;
    bit         saw_bp = 1'b0;
    bit         send_done = 1'b0;

    piso_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .enb        (enb),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .ser_out    (ser_out),
        .ser_valid  (ser_valid),
        .ser_first  (ser_first),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Serial-side collector, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            if (ser_valid) begin
                obs_q.push_back(ser_out);
                if (frame_done) n_done++;
                if (ser_first)  n_first++;
            end
            if (in_valid && enb && !in_ready) saw_bp = 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Called at a falling edge: one valid serial bit with its flags.
    task automatic exp_bit(input string tag, input logic b, input logic f, input logic d);
        check({tag, ".valid"}, ser_valid, 1);
        check({tag, ".bit"},   ser_out,   b);
        check({tag, ".first"}, ser_first, f);
        check({tag, ".done"},  frame_done, d);
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!ser_valid && n < 20) begin
            n++;
            @(negedge clk);
        end
        check({tag, ".start"}, ser_valid, 1);
    endtask

    task automatic sender();
        int g;
        while (tx_q.size() > 0) begin
            in_valid = 1'b1;
            in_data  = tx_q[0];
            g = 0;
            @(negedge clk);
            while (!in_ready && g < 200) begin
                g++;
                @(negedge clk);
            end
            check("send.ready", in_ready, 1);
            cyc();
            tx_q.delete(0);
        end
        in_valid = 1'b0;
    endtask

    task automatic expect_stream(input string tag, input logic [11:0] bits, input int n);
        wait_valid(tag);
        for (int k = 0; k < n; k++) begin
            if (k > 0) @(negedge clk);
            exp_bit(tag, bits[n-1-k], (k % 4) == 0, (k % 4) == 3);
        end
        @(negedge clk);
        check({tag, ".end_valid"}, ser_valid, 0);
        check({tag, ".end_busy"},  busy, 0);
    endtask

    task automatic rand_sender(input int n);
        int g;
        int gap;
        logic [3:0] w;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b0;
            gap = $urandom_range(0, 3);
            repeat (gap) begin
                in_data = 4'($urandom);
                cyc();
            end
            w = 4'($urandom);
            for (int b = 3; b >= 0; b--) exp_q.push_back(w[b]);
            in_valid = 1'b1;
            in_data  = w;
            g = 0;
            @(negedge clk);
            while (!in_ready && g < 200) begin
                g++;
                @(negedge clk);
            end
            check("rand.ready", in_ready, 1);
            cyc();
        end
        in_valid  = 1'b0;
        in_data   = 4'($urandom);
        send_done = 1'b1;
    endtask

    initial begin
        int g;
        int bad;

        rst = 1'b1; enb = 1'b0; in_valid = 1'b0; in_data = 4'h0;
        #3 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst.ser_valid",  ser_valid, 0);
        check("rst.ser_out",    ser_out, 0);
        check("rst.ser_first",  ser_first, 0);
        check("rst.frame_done", frame_done, 0);
        check("rst.busy",       busy, 0);
        check("rst.in_ready",   in_ready, 0);
        enb = 1'b1;
        #1 check("rst.in_ready_enb", in_ready, 0);
        cyc();
        cyc();
        rst = 1'b1;
        @(negedge clk);
        check("rel.in_ready",  in_ready, 1);
        check("rel.ser_valid", ser_valid, 0);
        check("rel.busy",      busy, 0);
        cyc();

        // Single word 4'hA
        in_valid = 1'b1; in_data = 4'hA;
        @(negedge clk);
        check("single.ready", in_ready, 1);
        cyc();
        in_valid = 1'b0; in_data = 4'h5;
        @(negedge clk);
        check("single.held_valid", ser_valid, 0);
        check("single.held_busy",  busy, 1);
        @(negedge clk); exp_bit("single0", 1'b1, 1'b1, 1'b0);
        @(negedge clk); exp_bit("single1", 1'b0, 1'b0, 1'b0);
        @(negedge clk); exp_bit("single2", 1'b1, 1'b0, 1'b0);
        @(negedge clk); exp_bit("single3", 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check("single.after_valid", ser_valid, 0);
        check("single.after_busy",  busy, 0);
        cyc();

        // Back-to-back 9, 6, F
        tx_q = '{4'h9, 4'h6, 4'hF};
        fork
            sender();
            expect_stream("b2b", 12'h96F, 12);
        join
        cyc();

        // Backpressure 3, C, 5
        saw_bp = 1'b0;
        tx_q = '{4'h3, 4'hC, 4'h5};
        fork
            sender();
            expect_stream("bp", 12'h3C5, 12);
        join
        check("bp.in_ready_dropped", saw_bp, 1);
        cyc();

        // Enable freeze inside 4'hB
        in_valid = 1'b1; in_data = 4'hB;
        @(negedge clk);
        check("frz.ready", in_ready, 1);
        cyc();
        in_valid = 1'b0; in_data = 4'h0;
        wait_valid("frz");
        exp_bit("frz0", 1'b1, 1'b1, 1'b0);
        @(negedge clk); exp_bit("frz1", 1'b0, 1'b0, 1'b0);
        cyc();
        enb = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("frz.hold_valid", ser_valid, 0);
            check("frz.hold_first", ser_first, 0);
            check("frz.hold_done",  frame_done, 0);
            check("frz.hold_out",   ser_out, 1);
            check("frz.hold_ready", in_ready, 0);
            check("frz.hold_busy",  busy, 1);
        end
        cyc();
        enb = 1'b1;
        @(negedge clk); exp_bit("frz2", 1'b1, 1'b0, 1'b0);
        @(negedge clk); exp_bit("frz3", 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        check("frz.after_valid", ser_valid, 0);
        cyc();

        // Reset in the middle of 4'h7
        in_valid = 1'b1; in_data = 4'h7;
        @(negedge clk);
        cyc();
        in_valid = 1'b0;
        wait_valid("mrst");
        exp_bit("mrst0", 1'b0, 1'b1, 1'b0);
        @(negedge clk); exp_bit("mrst1", 1'b1, 1'b0, 1'b0);
        @(negedge clk); exp_bit("mrst2", 1'b1, 1'b0, 1'b0);
        cyc();
        rst = 1'b0;
        #1;
        check("mrst.ser_valid",  ser_valid, 0);
        check("mrst.ser_out",    ser_out, 0);
        check("mrst.ser_first",  ser_first, 0);
        check("mrst.frame_done", frame_done, 0);
        check("mrst.busy",       busy, 0);
        check("mrst.in_ready",   in_ready, 0);
        cyc();
        rst = 1'b1;
        repeat (8) begin
            @(negedge clk);
            check("mrst.no_residual_valid", ser_valid, 0);
            check("mrst.no_residual_busy",  busy, 0);
        end
        cyc();

        // Random traffic with gaps and enable drops
        obs_q.delete();
        exp_q.delete();
        n_done = 0;
        n_first = 0;
        send_done = 1'b0;
        fork
            rand_sender(200);
            begin
                while (!send_done) begin
                    cyc();
                    enb = ($urandom_range(0, 7) != 0);
                end
            end
        join
        enb = 1'b1;
        g = 0;
        while (obs_q.size() < exp_q.size() && g < 500) begin
            cyc();
            g++;
        end
        repeat (3) cyc();
        check("rand.count", obs_q.size(), exp_q.size());
        bad = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) bad++;
        end
        check("rand.bits", bad, 0);
        check("rand.frame_done", n_done, 200);
        check("rand.ser_first", n_first, 200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
